// File: rtl/line_buffer_3row.sv
// line_buffer_3row: three-row sliding window over a raster pixel stream.
// Two line stores (LA = previous line, LB = the line before that) turn each
// incoming pixel into a vertical column triple (r-2, r-1, r) with one cycle
// of latency. Column/row counters track raster position; sof_in restarts
// the frame at (0,0).
// Optional feature: define LINEBUF_EDGE_REPLICATE_EN to emit triples from
// row 0 onward, replicating the top edge for the missing rows.

module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             sof_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             valid_out,
    output logic             eol_out
);

    localparam int COL_W = (PIC_WIDTH  > 1) ? $clog2(PIC_WIDTH)  : 1;
    localparam int ROW_W = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(PIC_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(PIC_HEIGHT - 1);

    // Line stores: LA holds line r-1, LB holds line r-2 at the current column.
    logic [WIDTH-1:0] la_mem [PIC_WIDTH];
    logic [WIDTH-1:0] lb_mem [PIC_WIDTH];

    logic [COL_W-1:0] col_q, col_d, pix_col;
    logic [ROW_W-1:0] row_q, row_d, pix_row;
    logic [WIDTH-1:0] la_old, lb_old;
    logic [WIDTH-1:0] dout1_q, dout1_d;
    logic [WIDTH-1:0] dout2_q, dout2_d;
    logic [WIDTH-1:0] dout3_q, dout3_d;
    logic             valid_q, valid_d;
    logic             eol_q, eol_d;

    // Position of the pixel on din (sof forces (0,0)) and the old store contents there.
    always_comb begin
        pix_col = sof_in ? '0 : col_q;
        pix_row = sof_in ? '0 : row_q;
        la_old  = la_mem[pix_col];
        lb_old  = lb_mem[pix_col];
    end

    // Next-state: counter advance with wrap, column triple and qualifiers.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        col_d   = col_q;
        row_d   = row_q;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        dout3_d = dout3_q;
        valid_d = 1'b0;
        eol_d   = 1'b0;
        if (valid_in) begin
            if (pix_col == COL_MAX) begin
                col_d = '0;
                row_d = (pix_row == ROW_MAX) ? '0 : pix_row + ROW_W'(1);
            end else begin
                col_d = pix_col + COL_W'(1);
                row_d = pix_row;
            end
            dout3_d = din;
            dout2_d = la_old;
            dout1_d = lb_old;
`ifdef LINEBUF_EDGE_REPLICATE_EN
            valid_d = 1'b1;
            if (pix_row == '0) begin
                dout2_d = din;
                dout1_d = din;
            end else if (pix_row == ROW_W'(1)) begin
                dout1_d = la_old;
            end
`else
            valid_d = (pix_row >= ROW_W'(2));
`endif
            eol_d = valid_d && (pix_col == COL_MAX);
        end
    end

    // Line store update: LA takes the new pixel, LB takes what LA held.
    // NOTE: the stores are deliberately not reset; rows 0/1 after reset are never flagged valid.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            la_mem[pix_col] <= din;
            lb_mem[pix_col] <= la_old;
        end
    end

    // Counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
            dout3_q <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            dout3_q <= dout3_d;
            valid_q <= valid_d;
            eol_q   <= eol_d;
        end
    end

    assign dout1     = dout1_q;
    assign dout2     = dout2_q;
    assign dout3     = dout3_q;
    assign valid_out = valid_q;
    assign eol_out   = eol_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Testbench for line_buffer_3row with a 4x4 frame of 8-bit pixels.
// A table of per-cycle vectors (inputs plus expected registered outputs)
// is built up front from hand-derived rules, then applied one per clock.

module tb_line_buffer_3row;

    localparam int W  = 8;
    localparam int PW = 4;
    localparam int PH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         sof_in;
    logic [W-1:0] din;
    logic [W-1:0] dout1, dout2, dout3;
    logic         valid_out, eol_out;

    int checks   = 0;
    int failures = 0;

    line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .din       (din),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .valid_out (valid_out),
        .eol_out   (eol_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         valid;
        logic         sof;
        logic [W-1:0] din;
        logic         e_valid;
        logic         e_eol;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [W-1:0] e3;
        logic         chk_d;   // compare dout1/dout2 (known contents)
    } vec_t;

    vec_t vecs[$];
    vec_t last;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Expected outputs after pixel p at stream index k since (0,0) of a frame.
    function automatic vec_t pix_vec(input logic [W-1:0] p, input logic sof, input int k);
        vec_t v;
        int   row;
        int   col;
        row       = (k / PW) % PH;
        col       = k % PW;
        v.rst     = 1'b0;
        v.valid   = 1'b1;
        v.sof     = sof;
        v.din     = p;
        v.e3      = p;
        v.e2      = p - 8'd4;
        v.e1      = p - 8'd8;
`ifdef LINEBUF_EDGE_REPLICATE_EN
        v.e_valid = 1'b1;
        if (row == 0) begin
            v.e1 = p;
            v.e2 = p;
        end else if (row == 1) begin
            v.e1 = p - 8'd4;
        end
`else
        v.e_valid = (row >= 2);
`endif
        v.e_eol   = v.e_valid && (col == PW - 1);
        v.chk_d   = v.e_valid;
        return v;
    endfunction

    task automatic add_pix(input logic [W-1:0] p, input logic sof, input int k);
        last = pix_vec(p, sof, k);
        vecs.push_back(last);
    endtask

    // Idle cycle with sof_in asserted: must be ignored, outputs held, valid low.
    task automatic add_gap();
        vec_t v;
        v         = last;
        v.valid   = 1'b0;
        v.sof     = 1'b1;
        v.din     = 8'hEE;
        v.e_valid = 1'b0;
        v.e_eol   = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic add_rst();
        vec_t v;
        v.rst = 1'b1; v.valid = 1'b0; v.sof = 1'b0; v.din = 8'h5A;
        v.e_valid = 1'b0; v.e_eol = 1'b0;
        v.e1 = '0; v.e2 = '0; v.e3 = '0; v.chk_d = 1'b1;
        last = v;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; din = '0;

        // Continuous frame with sof, then a second frame without sof (row wrap).
        add_rst(); add_rst();
        for (int p = 0; p < 32; p++) add_pix(8'(p), p == 0, p);

        // Same frame with an ignored-sof gap after every pixel.
        add_rst();
        for (int p = 0; p < 16; p++) begin
            add_pix(8'(p), p == 0, p);
            add_gap();
        end

        // sof re-asserted on pixel 0x06 restarts the frame there.
        add_rst();
        for (int p = 0; p < 6; p++) add_pix(8'(p), p == 0, p);
        for (int p = 6; p < 18; p++) add_pix(8'(p), p == 6, p - 6);

        // Reset mid-line after 0x0A, then restart without sof.
        add_rst();
        for (int p = 0; p <= 10; p++) add_pix(8'(p), p == 0, p);
        add_rst();
        for (int p = 0; p < 16; p++) add_pix(8'(p), 1'b0, p);

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            valid_in = vecs[i].valid;
            sof_in   = vecs[i].sof;
            din      = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid_out", i), 8'(valid_out), 8'(vecs[i].e_valid));
            check($sformatf("v%0d eol_out", i), 8'(eol_out), 8'(vecs[i].e_eol));
            check($sformatf("v%0d dout3", i), dout3, vecs[i].e3);
            if (vecs[i].chk_d) begin
                check($sformatf("v%0d dout2", i), dout2, vecs[i].e2);
                check($sformatf("v%0d dout1", i), dout1, vecs[i].e1);
            end
        end

        // Idle tail: last triple (0x07,0x0B,0x0F) must be held with valid low.
        for (int n = 0; n < 3; n++) begin
            rst = 1'b0; valid_in = 1'b0; sof_in = 1'b0; din = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            check($sformatf("idle%0d valid_out", n), 8'(valid_out), 8'h00);
            check($sformatf("idle%0d eol_out", n), 8'(eol_out), 8'h00);
            check($sformatf("idle%0d dout1", n), dout1, 8'h07);
            check($sformatf("idle%0d dout2", n), dout2, 8'h0B);
            check($sformatf("idle%0d dout3", n), dout3, 8'h0F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
